// File: rtl/i2c_write_scheduler.sv
// i2c_write_scheduler
//   Sequencer in front of the register-write frame engine for the PWM board.
//   After reset it replays INIT_TABLE, sending one frame per entry. After that
//   it grants single runtime register writes. It drives the level start/complete
//   handshake, puts idle gaps between frames and aborts frames that hang.
//
// Ports
//   controller_clk   clock, shared with the frame engine
//   i_rst_n          asynchronous active-low reset
//   i_retrigger      level; in IDLE, replays the init table from entry 0
//   i_req            runtime write request, held by the requester until ack
//   i_req_addr/data  runtime register address / data
//   o_req_ack        one-cycle pulse when the request is captured
//   o_register_addr  frame engine register address
//   o_data           frame engine data
//   o_start          frame engine start (level)
//   i_complete       frame engine complete (level)
//   o_busy           high in every state except IDLE
//   o_init_done      set when the last init entry finishes, cleared on retrigger
//   o_error          sticky; set by any handshake timeout
//   o_idx            current init-table index
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOAD    | addr/data stable; raise start on the next edge
// ISSUE   | start high; wait for complete (or time out)
// RELEASE | start low; wait for complete to drop (or time out)
// GAP     | idle inter-frame count-down, then next entry / IDLE
// IDLE    | waiting for retrigger or a runtime request

module i2c_write_scheduler #(
  parameter int unsigned            INIT_LEN       = 4,
  parameter logic [16*INIT_LEN-1:0] INIT_TABLE     = 64'h0104_0020_FE79_0010,
  parameter int unsigned            GAP_CYCLES     = 2,
  parameter int unsigned            TIMEOUT_CYCLES = 63
) (
  input  logic       controller_clk,
  input  logic       i_rst_n,
  input  logic       i_retrigger,
  input  logic       i_req,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_req_ack,
  output logic [7:0] o_register_addr,
  output logic [7:0] o_data,
  output logic       o_start,
  input  logic       i_complete,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_error,
  output logic [3:0] o_idx
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RELEASE = 3'd2,
    S_GAP     = 3'd3,
    S_IDLE    = 3'd4
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(INIT_LEN - 1);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LD   = 8'(GAP_CYCLES);
  localparam logic [15:0] ENTRY0   = INIT_TABLE[15:0];

  // Fixed 16-deep view of the table so a 4-bit index never runs off the end.
  logic [15:0] table_w [16];
  for (genvar k = 0; k < 16; k++) begin : g_tbl
    if (k < INIT_LEN) begin : g_used
      assign table_w[k] = INIT_TABLE[16*k +: 16];
    end else begin : g_pad
      assign table_w[k] = 16'h0000;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       init_mode_q, init_mode_d;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] gap_q, gap_d;
  logic [3:0] idx_nxt;

  assign idx_nxt = idx_q + 4'd1;

  always_ff @(posedge controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_LOAD;
      idx_q       <= 4'd0;
      addr_q      <= ENTRY0[15:8];
      data_q      <= ENTRY0[7:0];
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      init_mode_q <= 1'b1;
      tmr_q       <= 8'd0;
      gap_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      init_mode_q <= init_mode_d;
      tmr_q       <= tmr_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    start_d     = start_q;
    ack_d       = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    init_mode_d = init_mode_q;
    tmr_d       = tmr_q;
    gap_d       = gap_q;

    unique case (state_q)
      S_LOAD: begin
        start_d = 1'b1;
        tmr_d   = 8'd0;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (i_complete) begin
          start_d = 1'b0;
          tmr_d   = 8'd0;
          state_d = S_RELEASE;
        end else if (tmr_q == TMO_LAST) begin
          // Dropping start lets the engine fall back to its wait state.
          err_d   = 1'b1;
          start_d = 1'b0;
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end

      S_RELEASE: begin
        if (!i_complete) begin
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          gap_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end

      S_GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (init_mode_q) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = table_w[idx_nxt][15:8];
            data_d  = table_w[idx_nxt][7:0];
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        start_d = 1'b0;
        if (i_retrigger) begin
          idx_d       = 4'd0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          addr_d      = ENTRY0[15:8];
          data_d      = ENTRY0[7:0];
          init_mode_d = 1'b1;
          state_d     = S_LOAD;
        end else if (i_req) begin
          addr_d      = i_req_addr;
          data_d      = i_req_data;
          ack_d       = 1'b1;
          init_mode_d = 1'b0;
          state_d     = S_LOAD;
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_req_ack       = ack_q;
  assign o_register_addr = addr_q;
  assign o_data          = data_q;
  assign o_start         = start_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_init_done     = done_q;
  assign o_error         = err_q;
  assign o_idx           = idx_q;

endmodule

// File: doc/i2c_write_scheduler.md
Name: i2c_write_scheduler

Overview:
Sequencer that drives i2c_frame_output (register-write frame engine, slave 0x40 PWM board). After reset it replays a parameterised init table of {register, data} pairs, one frame per entry. It then grants single register-write requests from runtime logic (e.g. servo/PWM update). It owns the level-sensitive start/complete handshake of the frame engine, inter-frame gaps and hang recovery.

Parameters:
INIT_LEN, 4, number of init-table entries (1..16)
INIT_TABLE, {16'h0104,16'h0020,16'hFE79,16'h0010}, entry k = bits [16k+15:16k]; [15:8] register addr, [7:0] data; entry 0 sent first
GAP_CYCLES, 2, idle controller_clk cycles between frames (0..255)
TIMEOUT_CYCLES, 63, max cycles waiting on i_complete per phase before abort (1..255)

Ports:
controller_clk  input  1  clock, same clock as the frame engine FSM
i_rst_n  input  1  reset, asynchronous, active-low
i_retrigger  input  1  level; in IDLE restarts the init table from entry 0
i_req  input  1  runtime write request, held until o_req_ack
i_req_addr  input  8  runtime register address
i_req_data  input  8  runtime data
o_req_ack  output  1  one-cycle pulse: request captured
o_register_addr  output  8  to frame engine i_register_addr
o_data  output  8  to frame engine i_data
o_start  output  1  to frame engine i_start
i_complete  input  1  from frame engine o_complete
o_busy  output  1  high in any state except IDLE
o_init_done  output  1  high once last init entry finishes; cleared by retrigger
o_error  output  1  sticky; set on any timeout
o_idx  output  4  current init-table index

Behaviour:
- Reset (async): state=LOAD, idx=0, outputs = entry 0 addr/data, o_start=0, o_req_ack=0, o_init_done=0, o_error=0, counters 0. Init sequence begins with no external trigger.
- All outputs registered; transitions on posedge controller_clk.
- LOAD: addr/data already stable; o_start<=1; ->ISSUE. Start therefore rises one cycle after addr/data are valid.
- ISSUE: o_start held high, addr/data held.
  - i_complete==1: o_start<=0, ->RELEASE.
  - Timer reaches TIMEOUT_CYCLES: o_error<=1, o_start<=0, ->GAP (entry skipped).
- RELEASE: wait i_complete==0, then ->GAP with gap counter=GAP_CYCLES. Same timeout rule applies: o_error<=1, ->GAP.
- GAP: count down; at 0 (immediately if GAP_CYCLES=0):
  - Init mode, idx<INIT_LEN-1: idx++, load entry idx, ->LOAD.
  - Init mode, last entry: o_init_done<=1, ->IDLE.
  - Runtime mode: ->IDLE.
- IDLE: o_start=0.
  - i_retrigger=1: idx=0, o_init_done<=0, o_error<=0, load entry 0, init mode, ->LOAD. Retrigger has priority over i_req.
  - Else i_req=1: latch i_req_addr/i_req_data into o_register_addr/o_data, o_req_ack<=1 for exactly one cycle, runtime mode, ->LOAD.
- i_req outside IDLE (including during init) is not acked; the requester holds it. i_retrigger outside IDLE is ignored.
- Timeout counter is 8-bit, cleared on entry to ISSUE and RELEASE. Abort releases o_start, so the frame engine returns to its wait state.
- Reset mid-frame: o_start drops asynchronously; init restarts from entry 0.
- Latency: IDLE accept -> o_start high = 2 cycles. i_complete high -> o_start low = 1 cycle.

Test Plan:
- Reset with frame-engine model (complete 31 cycles after start, drops 1 cycle after start low) -> four frames {00,10},{FE,79},{00,20},{01,04} in order. Each has ≥2 idle cycles between complete falling and next start. o_init_done=1 after the fourth; o_error=0.
- After init, i_req with addr=0x06, data=0x7F -> o_req_ack single pulse; o_register_addr=0x06, o_data=0x7F before o_start rises; one frame; o_busy falls after gap.
- i_req asserted during init entry 1 -> no ack until o_init_done=1; then ack and frame 0x06/0x7F follows the four init frames.
- Model never raises i_complete on entry 2 -> o_start falls after 63 cycles; o_error=1; entry 3 still sent; o_init_done=1.
- i_retrigger and i_req together in IDLE -> init replay wins; o_error cleared; request acked only after replay finishes.
- i_rst_n low mid-frame entry 2 -> o_start=0 immediately; after release, sequence restarts at entry 0 with o_idx=0.
